mux_2x1_arbiter: RTL and testbench

//  Shares one 2:1 mux datapath between requesters A and B using valid/ready handshakes.
//  The FSM grants one requester at a time and drives the mux select from the grant.

---
 rtl/mux_2x1_arbiter.sv | 136 +++++++++++++
 tb/tb_mux_2x1_arbiter.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_2x1_arbiter.sv
// Two-requester valid/ready arbiter sharing one registered 2:1 mux stage.
// Define MUX_ARB_FIXED_PRI_EN for fixed A-priority; default is round-robin.
module mux_2x1_arbiter #(
  parameter int DW        = 8,
  parameter int MAX_BURST = 4,
  parameter int CNT_W     = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          a_valid,
  input  logic [DW-1:0] a,
  output logic          a_ready,
  input  logic          b_valid,
  input  logic [DW-1:0] b,
  output logic          b_ready,
  output logic          sel,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  output logic          out_src,
  input  logic          out_ready
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GNT_A = 2'd1,
    S_GNT_B = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LP_CNT_MAX =
    CNT_W'(MAX_BURST - 1);

  state_t          r_state;
  logic [CNT_W-1:0] r_cnt;
  logic            r_out_valid;
  logic [DW-1:0]   r_out_data;
  logic            r_out_src;
`ifndef MUX_ARB_FIXED_PRI_EN
  logic            r_last;
`endif

  logic            w_free;
  logic            w_sel;
  logic            w_acc_a;
  logic            w_acc_b;
  logic            w_acc;
  logic [DW-1:0]   w_mux;
  logic            w_cnt_end;
  state_t          w_pick_idle;
  state_t          w_pick_end_a;
  state_t          w_pick_end_b;

  assign w_free    = !r_out_valid | out_ready;
  assign w_sel     = (r_state == S_GNT_B);
  assign w_mux     = w_sel ? b : a;
  assign w_acc_a   = (r_state == S_GNT_A) & a_valid & w_free;
  assign w_acc_b   = (r_state == S_GNT_B) & b_valid & w_free;
  assign w_acc     = w_acc_a | w_acc_b;
  assign w_cnt_end = (r_cnt == LP_CNT_MAX);

`ifdef MUX_ARB_FIXED_PRI_EN
  // A wins every arbitration it takes part in, even its own burst end
  assign w_pick_idle  = a_valid ? S_GNT_A :
                        b_valid ? S_GNT_B : S_IDLE;
  assign w_pick_end_a = w_pick_idle;
  assign w_pick_end_b = w_pick_idle;
`else
  // r_last=1 means B was served last, so A wins a tie
  assign w_pick_idle  = (a_valid & b_valid) ?
                          (r_last ? S_GNT_A : S_GNT_B) :
                        a_valid ? S_GNT_A :
                        b_valid ? S_GNT_B : S_IDLE;
  assign w_pick_end_a = b_valid ? S_GNT_B : S_IDLE;
  assign w_pick_end_b = a_valid ? S_GNT_A : S_IDLE;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_src   <= 1'b0;
`ifndef MUX_ARB_FIXED_PRI_EN
      r_last      <= 1'b1;
`endif
    end else begin
      if (w_acc) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_mux;
        r_out_src   <= w_sel;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end

      unique case (r_state)
        S_IDLE: begin
          r_state <= w_pick_idle;
        end
        S_GNT_A: begin
          if (!a_valid || (w_free && w_cnt_end)) begin
            r_cnt   <= '0;
            r_state <= w_pick_end_a;
`ifndef MUX_ARB_FIXED_PRI_EN
            r_last  <= 1'b0;
`endif
          end else if (w_free) begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_GNT_B: begin
          if (!b_valid || (w_free && w_cnt_end)) begin
            r_cnt   <= '0;
            r_state <= w_pick_end_b;
`ifndef MUX_ARB_FIXED_PRI_EN
            r_last  <= 1'b1;
`endif
          end else if (w_free) begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign a_ready   = (r_state == S_GNT_A) & w_free;
  assign b_ready   = (r_state == S_GNT_B) & w_free;
  assign sel       = w_sel;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_src   = r_out_src;

endmodule

// File: tb/tb_mux_2x1_arbiter.sv
// Randomized bench for mux_2x1_arbiter against a grant/burst model,
// plus directed scenarios with literal expectations.
module tb_mux_2x1_arbiter;

  localparam int DW = 8;
  localparam int MB = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          a_valid, b_valid, out_ready;
  logic [DW-1:0] a, b;
  logic          a_ready, b_ready, sel;
  logic          out_valid, out_src;
  logic [DW-1:0] out_data;

  mux_2x1_arbiter #(.DW(DW), .MAX_BURST(MB), .CNT_W(2)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a(a), .a_ready(a_ready),
    .b_valid(b_valid), .b(b), .b_ready(b_ready),
    .sel(sel),
    .out_valid(out_valid), .out_data(out_data),
    .out_src(out_src), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc_n = 0;

  always @(posedge clk) cyc_n <= cyc_n + 1;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // owner: 0 nobody, 1 A, 2 B. last: owner id served last.
  int            m_own;
  int            m_beats;
  int            m_last;
  bit            m_ov;
  logic [DW-1:0] m_od;
  bit            m_os;
  bit            m_known = 0;

  function automatic int arb(bit av, bit bv, int last);
`ifdef MUX_ARB_FIXED_PRI_EN
    return av ? 1 : (bv ? 2 : 0);
`else
    if (av && bv) return (last == 1) ? 2 : 1;
    return av ? 1 : (bv ? 2 : 0);
`endif
  endfunction

  function automatic int rearb(int x, bit av, bit bv);
`ifdef MUX_ARB_FIXED_PRI_EN
    return arb(av, bv, x);
`else
    if (x == 1) return bv ? 2 : 0;
    return av ? 1 : 0;
`endif
  endfunction

  initial begin
    bit free, acc_a, acc_b, xv;
    int x;
    forever begin
      @(negedge clk);
      if (m_known) begin
        free = !m_ov || out_ready;
        chk("out_valid", out_valid, m_ov);
        chk("out_data", out_data, m_od);
        chk("out_src", out_src, m_os);
        chk("sel", sel, m_own == 2);
        chk("a_ready", a_ready, (m_own == 1) && free);
        chk("b_ready", b_ready, (m_own == 2) && free);
      end
      if (rst) begin
        m_known = 1;
        m_own = 0; m_beats = 0; m_last = 2;
        m_ov = 0; m_od = '0; m_os = 0;
      end else if (m_known) begin
        free  = !m_ov || out_ready;
        acc_a = (m_own == 1) && a_valid && free;
        acc_b = (m_own == 2) && b_valid && free;
        if (acc_a || acc_b) begin
          m_ov = 1;
          m_od = acc_a ? a : b;
          m_os = acc_b;
        end else if (out_ready) begin
          m_ov = 0;
        end
        if (m_own == 0) begin
          m_own = arb(a_valid, b_valid, m_last);
        end else begin
          x  = m_own;
          xv = (x == 1) ? a_valid : b_valid;
          if (xv && free) m_beats++;
          if (!xv || m_beats == MB) begin
            m_last  = x;
            m_beats = 0;
            m_own   = rearb(x, a_valid, b_valid);
          end
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1; a_valid = 0; b_valid = 0;
    step(); step();
    rst = 0;
  endtask

  // Present one beat and wait (bounded) for it to be accepted.
  task automatic send(input bit src, input logic [DW-1:0] d,
                      output int cyc);
    bit ok;
    ok = 0;
    if (src) begin b = d; b_valid = 1; end
    else     begin a = d; a_valid = 1; end
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (src ? b_ready : a_ready) begin ok = 1; break; end
    end
    if (!ok) chk("send_timeout", 0, 1);
    step();
    cyc = cyc_n;
  endtask

  // ---------------- directed + random ----------------
  initial begin
    int c1, c2, c3, n;
    bit srcs[12];
    rst = 1; a_valid = 1; b_valid = 1; out_ready = 1;
    a = 8'hAA; b = 8'hBB;
    step(); step();
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_a_ready", a_ready, 0);
    chk("rst_b_ready", b_ready, 0);
    chk("rst_sel", sel, 0);
    chk("rst_out_data", out_data, 0);
    step();

    // A only, three back-to-back beats
    rst = 0; b_valid = 0;
    send(0, 8'h11, c1);
    chk("t2_d1", {out_valid, out_src, out_data}, {2'b10, 8'h11});
    send(0, 8'h22, c2);
    chk("t2_d2", {out_valid, out_src, out_data}, {2'b10, 8'h22});
    send(0, 8'h33, c3);
    chk("t2_d3", {out_valid, out_src, out_data}, {2'b10, 8'h33});
    chk("t2_gap12", c2 - c1, 1);
    chk("t2_gap23", c3 - c2, 1);
    a_valid = 0;
    step(); step();

    // Contention: burst pattern of sources
    do_reset();
    a_valid = 1; b_valid = 1; out_ready = 1;
    a = 8'hA0; b = 8'hB0;
    n = 0;
    for (int i = 0; i < 60 && n < 12; i++) begin
      @(negedge clk);
      if (a_ready)      begin srcs[n] = 0; n++; end
      else if (b_ready) begin srcs[n] = 1; n++; end
      step();
      a = a + 8'd1; b = b + 8'd1;
    end
    chk("t3_count", n, 12);
    for (int i = 0; i < 12; i++) begin
`ifdef MUX_ARB_FIXED_PRI_EN
      chk($sformatf("t3_src%0d", i), srcs[i], 0);
`else
      chk($sformatf("t3_src%0d", i), srcs[i], (i / 4) % 2);
`endif
    end
    a_valid = 0; b_valid = 0;

    // Backpressure after first A beat
    do_reset();
    out_ready = 1;
    send(0, 8'h41, c1);
    chk("t4_first", out_data, 8'h41);
    out_ready = 0; a = 8'h42;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t4_hold_rdy", a_ready, 0);
      chk("t4_hold_dat", {out_valid, out_data}, {1'b1, 8'h41});
      step();
    end
    out_ready = 1;
    send(0, 8'h42, c1);
    chk("t4_d42", out_data, 8'h42);
    send(0, 8'h43, c1);
    chk("t4_d43", out_data, 8'h43);
    send(0, 8'h44, c1);
    chk("t4_d44", out_data, 8'h44);
    @(negedge clk);
`ifdef MUX_ARB_FIXED_PRI_EN
    chk("t4_burst_end", a_ready, 1);
`else
    chk("t4_burst_end", a_ready, 0);
`endif
    step();
    a_valid = 0;
    step(); step();

    // A drops valid mid-burst with B waiting
    do_reset();
    b = 8'h5B; b_valid = 1;
    send(0, 8'h51, c1);
    send(0, 8'h52, c1);
    a_valid = 0;
    @(negedge clk);
    chk("t5_sel_before", sel, 0);
    step();
    @(negedge clk);
    chk("t5_sel_after", sel, 1);
    chk("t5_b_ready", b_ready, 1);
    step();
    chk("t5_b_beat", {out_valid, out_src, out_data}, {2'b11, 8'h5B});
    b_valid = 0;
    step(); step();

    // Randomized traffic with sticky valids
    for (int i = 0; i < 3000; i++) begin
      step();
      rst = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 9) < 3) a_valid = $urandom_range(0, 3) != 0;
      if ($urandom_range(0, 9) < 3) b_valid = $urandom_range(0, 3) != 0;
      a = DW'($urandom);
      b = DW'($urandom);
      out_ready = $urandom_range(0, 9) < 7;
    end
    step(); step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout t=%0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
